// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: drain FSM encoding and FIFO sizing.
package uart_tx_sched_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 8;
  localparam int LEVEL_W            = 5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ISSUE     = 2'b01,
    ST_WAIT_BUSY = 2'b10,
    ST_WAIT_DONE = 2'b11
  } drain_state_t;

endpackage

// File: rtl/uart_tx_sched_sync_fifo.sv
// Single-clock byte FIFO with show-ahead head output and registered occupancy count.
module sync_fifo
  import uart_tx_sched_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int WIDTH = 8
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == LEVEL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign level   = count;

  // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; pointers and count already define which entries are valid.
  always_ff @(posedge I_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin byte scheduler feeding a shared FIFO drained into a UART transmitter.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic               I_req0_valid,
  input  logic [7:0]         I_req0_data,
  output logic               O_req0_ready,
  input  logic               I_req1_valid,
  input  logic [7:0]         I_req1_data,
  output logic               O_req1_ready,
  output logic [7:0]         O_tx_data,
  output logic               O_tx_exec,
  input  logic               I_tx_ready,
  output logic [LEVEL_W-1:0] O_level,
  output logic               O_busy
);

  drain_state_t state_q;
  drain_state_t state_d;
  logic         prio_q;
  logic         grant0;
  logic         grant1;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic [7:0]   fifo_dout;
  logic [7:0]   push_data;
  logic         load_data;
  logic [7:0]   tx_data_q;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .I_clk   (I_clk),
    .I_reset (I_reset),
    .push    (grant0 || grant1),
    .pop     (fifo_pop),
    .din     (push_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (O_level)
  );

  // prio_q=0 favours requester 0; a full FIFO blocks both even if it pops this cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!I_reset && !fifo_full) begin
      if (I_req0_valid && (!I_req1_valid || !prio_q)) grant0 = 1'b1;
      else if (I_req1_valid)                          grant1 = 1'b1;
    end
  end

  assign O_req0_ready = grant0;
  assign O_req1_ready = grant1;
  assign push_data    = grant1 ? I_req1_data : I_req0_data;

  always_ff @(posedge I_clk) begin
    if (I_reset)     prio_q <= 1'b0;
    else if (grant0) prio_q <= 1'b1;
    else if (grant1) prio_q <= 1'b0;
  end

  // The head byte is captured on IDLE->ISSUE so it is already stable while exec is high.
  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    load_data = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && I_tx_ready) begin
          state_d   = ST_ISSUE;
          load_data = 1'b1;
        end
      end
      ST_ISSUE: begin
        fifo_pop = 1'b1;
        state_d  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: if (!I_tx_ready) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (I_tx_ready)  state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q   <= ST_IDLE;
      tx_data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      if (load_data) tx_data_q <= fifo_dout;
    end
  end

  assign O_tx_data = tx_data_q;
  assign O_tx_exec = (state_q == ST_ISSUE);
  assign O_busy    = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a simple UART transmitter model that logs every issued byte.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1;
  logic [7:0] d0, d1;
  logic       r0, r1;
  logic [7:0] tx_data;
  logic       tx_exec;
  logic       tx_ready;
  logic [4:0] level;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // transmitter model state
  logic       model_ready = 1'b1;
  logic       hold_low    = 1'b0;
  int         busy_len    = 2;
  int         busy_cnt    = 0;
  logic       exec_prev   = 1'b0;
  int         exec_cnt    = 0;
  int         dbl_cnt     = 0;
  logic [7:0] cap_q[$];

  assign tx_ready = model_ready && !hold_low;

  uart_tx_sched #(.FIFO_DEPTH(8)) dut (
    .I_clk        (clk),
    .I_reset      (rst),
    .I_req0_valid (v0),
    .I_req0_data  (d0),
    .O_req0_ready (r0),
    .I_req1_valid (v1),
    .I_req1_data  (d1),
    .O_req1_ready (r1),
    .O_tx_data    (tx_data),
    .O_tx_exec    (tx_exec),
    .I_tx_ready   (tx_ready),
    .O_level      (level),
    .O_busy       (busy)
  );

  always #5 clk = ~clk;

  // Transmitter drops ready right after seeing exec and stays busy for busy_len sampled cycles.
  always @(negedge clk) begin
    if (tx_exec) begin
      cap_q.push_back(tx_data);
      model_ready <= 1'b0;
      busy_cnt    <= busy_len;
      exec_cnt    <= exec_cnt + 1;
      if (exec_prev) dbl_cnt <= dbl_cnt + 1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) model_ready <= 1'b1;
    end
    exec_prev <= tx_exec;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int req, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    if (req == 0) begin v0 = 1'b1; d0 = d; end
    else          begin v1 = 1'b1; d1 = d; end
    #1;
    for (int k = 0; k < 300; k++) begin
      if ((req == 0) ? r0 : r1) begin ok = 1'b1; break; end
      step();
    end
    total++;
    if (!ok) begin bad++; $display("FAIL send_timeout: req%0d byte %02h never accepted", req, d); end
    step();
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (!busy && tx_ready) begin ok = 1'b1; break; end
      step();
    end
    total++;
    if (!ok) begin bad++; $display("FAIL idle_timeout: busy=%0b tx_ready=%0b want idle", busy, tx_ready); end
  endtask

  task automatic wait_exec(output bit found);
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (tx_exec) begin found = 1'b1; break; end
      step();
    end
    total++;
    if (!found) begin bad++; $display("FAIL exec_timeout: no exec pulse seen"); end
  endtask

  // Counts cycles from the current exec pulse to the next one.
  task automatic exec_gap(output int gap);
    gap = 0;
    for (int k = 0; k < 400; k++) begin
      step();
      gap++;
      if (tx_exec) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 8'hEE; d1 = 8'hDD;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++; if ({r0, r1} !== 2'b00) begin bad++; $display("FAIL reset_readys: got %02b want 00", {r0, r1}); end
    total++; if (tx_exec !== 1'b0) begin bad++; $display("FAIL reset_exec: got %0b want 0", tx_exec); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h want 00", tx_data); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    step();
    total++; if ({level, busy, tx_exec} !== 7'd0) begin bad++; $display("FAIL post_reset: level=%0d busy=%0b exec=%0b want 0/0/0", level, busy, tx_exec); end
  endtask

  task automatic test_contention();
    logic [7:0] exp [8] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
    int i0, i1;
    logic g0, g1;
    i0 = 0; i1 = 0;
    cap_q.delete();
    for (int k = 0; k < 100 && !(i0 == 4 && i1 == 4); k++) begin
      v0 = (i0 < 4); d0 = 8'h10 + 8'(i0);
      v1 = (i1 < 4); d1 = 8'h20 + 8'(i1);
      #1;
      g0 = r0; g1 = r1;
      total++; if (g0 && g1) begin bad++; $display("FAIL contention_onehot: both readys high"); end
      step();
      if (g0) i0++;
      if (g1) i1++;
    end
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();
    total++; if (cap_q.size() !== 8) begin bad++; $display("FAIL contention_count: got %0d want 8", cap_q.size()); end
    for (int i = 0; i < 8 && i < cap_q.size(); i++) begin
      total++; if (cap_q[i] !== exp[i]) begin bad++; $display("FAIL contention_order[%0d]: got %02h want %02h", i, cap_q[i], exp[i]); end
    end
  endtask

  task automatic test_single();
    int start_cnt;
    start_cnt = exec_cnt;
    cap_q.delete();
    v0 = 1'b1; d0 = 8'hA5;
    #1;
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL single_ready: got %0b want 1", r0); end
    step();
    v0 = 1'b0;
    total++; if (level !== 5'd1) begin bad++; $display("FAIL single_level1: got %0d want 1", level); end
    total++; if (tx_exec !== 1'b0) begin bad++; $display("FAIL single_exec_early: got %0b want 0", tx_exec); end
    step();
    total++; if (tx_exec !== 1'b1) begin bad++; $display("FAIL single_exec: got %0b want 1", tx_exec); end
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_data: got %02h want a5", tx_data); end
    wait_idle();
    total++; if (level !== 5'd0) begin bad++; $display("FAIL single_level0: got %0d want 0", level); end
    total++; if (exec_cnt - start_cnt !== 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", exec_cnt - start_cnt); end
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_data_hold: got %02h want a5", tx_data); end
  endtask

  task automatic test_push_pop();
    cap_q.delete();
    hold_low = 1'b1;
    send(0, 8'h41);
    hold_low = 1'b0;
    step();
    total++; if (tx_exec !== 1'b1) begin bad++; $display("FAIL pushpop_exec: got %0b want 1", tx_exec); end
    v0 = 1'b1; d0 = 8'h42;
    #1;
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL pushpop_ready: got %0b want 1", r0); end
    step();
    v0 = 1'b0;
    total++; if (level !== 5'd1) begin bad++; $display("FAIL pushpop_level: got %0d want 1", level); end
    wait_idle();
    total++; if (cap_q.size() !== 2 || cap_q[0] !== 8'h41 || cap_q[1] !== 8'h42) begin
      bad++; $display("FAIL pushpop_order: got %0d bytes want 41,42", cap_q.size());
    end
  endtask

  task automatic test_full();
    cap_q.delete();
    hold_low = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v0 = 1'b1; d0 = 8'h30 + 8'(i);
      #1;
      total++; if (r0 !== 1'b1) begin bad++; $display("FAIL full_accept[%0d]: got %0b want 1", i, r0); end
      step();
    end
    d0 = 8'h38;
    #1;
    total++; if (level !== 5'd8) begin bad++; $display("FAIL full_level: got %0d want 8", level); end
    total++; if (r0 !== 1'b0) begin bad++; $display("FAIL full_ready9: got %0b want 0", r0); end
    step();
    total++; if (r0 !== 1'b0) begin bad++; $display("FAIL full_ready9_hold: got %0b want 0", r0); end
    hold_low = 1'b0;
    step();
    total++; if (tx_exec !== 1'b1 || r0 !== 1'b0) begin
      bad++; $display("FAIL full_pop_cycle: exec=%0b ready=%0b want exec=1 ready=0", tx_exec, r0);
    end
    step();
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL full_after_pop: got %0b want 1", r0); end
    step();
    v0 = 1'b0;
    total++; if (level !== 5'd8) begin bad++; $display("FAIL full_refill: got %0d want 8", level); end
    wait_idle();
    total++; if (cap_q.size() !== 9) begin bad++; $display("FAIL full_count: got %0d want 9", cap_q.size()); end
    for (int i = 0; i < 9 && i < cap_q.size(); i++) begin
      total++; if (cap_q[i] !== 8'h30 + 8'(i)) begin bad++; $display("FAIL full_order[%0d]: got %02h want %02h", i, cap_q[i], 8'h30 + 8'(i)); end
    end
  endtask

  task automatic test_handshake();
    bit found;
    int gap;
    busy_len = 100;
    send(1, 8'h55);
    send(1, 8'h66);
    wait_exec(found);
    exec_gap(gap);
    total++; if (gap !== 102) begin bad++; $display("FAIL handshake_gap: got %0d want 102", gap); end
    total++; if (tx_data !== 8'h66) begin bad++; $display("FAIL handshake_data: got %02h want 66", tx_data); end
    wait_idle();
    busy_len = 2;
  endtask

  task automatic test_back_to_back();
    bit found;
    int gap;
    hold_low = 1'b1;
    send(0, 8'h91);
    send(1, 8'h92);
    send(0, 8'h93);
    hold_low = 1'b0;
    wait_exec(found);
    for (int i = 0; i < 2; i++) begin
      exec_gap(gap);
      total++; if (gap !== 4) begin bad++; $display("FAIL b2b_gap[%0d]: got %0d want 4", i, gap); end
    end
    wait_idle();
    total++; if (dbl_cnt !== 0) begin bad++; $display("FAIL exec_width: got %0d long pulses want 0", dbl_cnt); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int stray;
    busy_len = 50;
    hold_low = 1'b1;
    for (int i = 0; i < 6; i++) send(0, 8'hC0 + 8'(i));
    hold_low = 1'b0;
    wait_exec(found);
    step();
    step();
    total++; if (level !== 5'd5 || tx_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL resetmid_pre: level=%0d ready=%0b busy=%0b want 5/0/1", level, tx_ready, busy);
    end
    rst = 1'b1;
    step();
    total++; if (level !== 5'd0) begin bad++; $display("FAIL resetmid_level: got %0d want 0", level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL resetmid_busy: got %0b want 0", busy); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL resetmid_data: got %02h want 00", tx_data); end
    rst = 1'b0;
    busy_len = 2;
    stray = 0;
    for (int k = 0; k < 80; k++) begin
      if (tx_exec) stray++;
      step();
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL resetmid_stray: got %0d exec want 0", stray); end
    send(1, 8'h77);
    wait_exec(found);
    total++; if (tx_data !== 8'h77) begin bad++; $display("FAIL resetmid_new: got %02h want 77", tx_data); end
    wait_idle();
  endtask

  task automatic test_wrap();
    cap_q.delete();
    for (int i = 0; i < 20; i++) send(1, 8'(i));
    wait_idle();
    total++; if (cap_q.size() !== 20) begin bad++; $display("FAIL wrap_count: got %0d want 20", cap_q.size()); end
    for (int i = 0; i < 20 && i < cap_q.size(); i++) begin
      total++; if (cap_q[i] !== 8'(i)) begin bad++; $display("FAIL wrap_order[%0d]: got %02h want %02h", i, cap_q[i], 8'(i)); end
    end
  endtask

  initial begin
    v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00; rst = 1'b1;
    test_reset();
    test_contention();
    test_single();
    test_push_pop();
    test_full();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, byte FIFO depth; power of two, 2..16.
REQ-002 I_clk  in  1  clock; all logic on rising edge.
REQ-003 I_reset  in  1  synchronous, active-high reset.
REQ-004 I_req0_valid  in  1  requester 0 has a byte.
REQ-005 I_req0_data  in  8  requester 0 byte.
REQ-006 O_req0_ready  out  1  requester 0 byte accepted this cycle when valid and ready are both high.
REQ-007 I_req1_valid, I_req1_data, O_req1_ready  same widths and meanings as REQ-004..006, for requester 1.
REQ-008 O_tx_data  out  8  byte to the UART transmitter.
REQ-009 O_tx_exec  out  1  one-cycle start pulse to the UART transmitter.
REQ-010 I_tx_ready  in  1  UART transmitter idle.
REQ-011 O_level  out  5  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-012 O_busy  out  1  high when the FIFO is non-empty or the drain FSM is not in IDLE.

Function
REQ-013 Requester bytes SHALL enter a shared FIFO; bytes SHALL leave it, in order, to the UART transmitter.
REQ-014 At most one requester SHALL be granted per cycle, and only when the FIFO is not full.
REQ-015 O_reqN_ready SHALL be combinational from the current valids, the FIFO-full flag and the priority pointer.
REQ-016 Arbitration SHALL be round-robin:
- Reset priority goes to requester 0.
- After a transfer from requester N, priority goes to the other requester.
- A lone valid requester is granted every non-full cycle.
REQ-017 Full-FIFO rule: both readys SHALL be low, even if a pop occurs in the same cycle.
REQ-018 A same-cycle push and pop SHALL be legal when the FIFO is not full; O_level is then unchanged.
REQ-019 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 O_level SHALL update on the cycle after each push or pop.
REQ-021 The drain FSM SHALL have the states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-022 IDLE -> ISSUE when the FIFO is non-empty and I_tx_ready=1; otherwise remain in IDLE.
REQ-023 ISSUE (exactly one cycle):
- O_tx_exec=1.
- O_tx_data = FIFO head, registered.
- The head is popped.
- Next state is WAIT_BUSY.
REQ-024 WAIT_BUSY -> WAIT_DONE when I_tx_ready=0; this allows for the transmitter lowering ready one cycle after exec.
REQ-025 WAIT_DONE -> IDLE when I_tx_ready=1.
REQ-026 Minimum spacing between O_tx_exec pulses SHALL be 4 cycles.
REQ-027 O_tx_exec SHALL be 0 in every state except ISSUE.
REQ-028 O_tx_data SHALL hold its last issued value until the next ISSUE.
REQ-029 Pushes SHALL continue during transmission, independent of the drain FSM state.

Reset
REQ-030 Reset outputs and state:
- O_tx_exec=0, O_tx_data=8'h00, O_level=0, O_busy=0.
- FSM in IDLE.
- Pointers at 0.
- Priority to requester 0.
REQ-031 Reset mid-operation SHALL discard all FIFO contents and any in-progress handshake.
REQ-032 O_req0_ready and O_req1_ready SHALL be 0 while I_reset=1.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (2-bit constants) and the FIFO_DEPTH default.
REQ-034 The FIFO SHALL be a separate sub-module, sync_fifo:
- Parameters DEPTH and WIDTH=8.
- Ports: push, pop, din, dout, full, empty, level.
REQ-035 The arbiter and drain FSM SHALL reside in uart_tx_sched.

Verification
REQ-036 Single byte: req0 sends 8'hA5 with I_tx_ready=1 -> one O_tx_exec pulse with O_tx_data=8'hA5; O_level returns to 0.
REQ-037 Contention: both valid continuously, req0 sends 8'h10..13 and req1 sends 8'h20..23 -> UART order 10,20,11,21,12,22,13,23.
REQ-038 Full FIFO:
- Stimulus: hold I_tx_ready=0 and push 9 bytes.
- Response: 8 accepted; O_level=8; readys low on the 9th attempt.
- Then release I_tx_ready: the 9th byte is accepted after the first pop.
REQ-039 Handshake: model the transmitter dropping ready one cycle after exec and holding it low for 100 cycles -> no second exec until ready returns to 1.
REQ-040 Reset mid-transfer: assert I_reset with O_level=5 while in WAIT_DONE -> next cycle O_level=0, O_busy=0, no exec until new data arrives.
REQ-041 Wrap-around: stream 20 bytes 8'h00..8'h13 from req1 -> all emitted in order, none lost or duplicated.
